// File: rtl/wb_dma.sv
// wb_dma: write-back DMA engine. Packs 16-bit result elements two per
// 32-bit word and writes them to consecutive word addresses.
module wb_dma #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 16,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [ADDR_W-1:0]   wb_base,
  input  logic [LEN_W-1:0]    wb_len,
  output logic                wb_done,
  input  logic [DATA_W-1:0]   om_data,
  input  logic                om_valid,
  output logic                om_ready,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [2*DATA_W-1:0] mem_wdata,
  output logic [1:0]          mem_hen,
  input  logic                mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                lane_q, lane_d;
  logic [2*DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]          hen_q, hen_d;

  logic wb_ready_q;
  logic wb_done_q;
  logic om_ready_q;
  logic mem_req_q;

  logic accept;
  logic xfer;
  logic ack;

  assign accept = wb_valid && wb_ready_q;
  assign xfer   = om_valid && om_ready_q;
  assign ack    = mem_ack && mem_req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    hen_d   = hen_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = wb_base;
          rem_d   = wb_len;
          lane_d  = 1'b0;
          wdata_d = '0;
          hen_d   = 2'b00;
          if (wb_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (xfer) begin
          rem_d = rem_q - LEN_W'(1);
          if (lane_q) begin
            wdata_d[2*DATA_W-1:DATA_W] = om_data;
            hen_d   = 2'b11;
            state_d = S_WRITE;
          end else begin
            wdata_d[DATA_W-1:0] = om_data;
            lane_d = 1'b1;
            // last element landing in the low half: odd tail
            if (rem_q == LEN_W'(1)) begin
              hen_d   = 2'b01;
              state_d = S_WRITE;
            end
          end
        end
      end
      S_WRITE: begin
        if (ack) begin
          addr_d  = addr_q + ADDR_W'(1);
          lane_d  = 1'b0;
          wdata_d = '0;
          hen_d   = 2'b00;
          if (rem_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      rem_q      <= '0;
      lane_q     <= 1'b0;
      wdata_q    <= '0;
      hen_q      <= 2'b00;
      wb_ready_q <= 1'b1;
      wb_done_q  <= 1'b0;
      om_ready_q <= 1'b0;
      mem_req_q  <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      hen_q      <= hen_d;
      wb_ready_q <= (state_d == S_IDLE);
      wb_done_q  <= (state_d == S_DONE);
      om_ready_q <= (state_d == S_COLLECT);
      mem_req_q  <= (state_d == S_WRITE);
    end
  end

  assign wb_ready  = wb_ready_q;
  assign wb_done   = wb_done_q;
  assign om_ready  = om_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_hen   = hen_q;

endmodule

// File: tb/tb_wb_dma.sv
// tb_wb_dma: directed table-driven bench for wb_dma plus
// hand-written reset and backpressure sequences.
module tb_wb_dma;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [23:0] wb_base;
  logic [15:0] wb_len;
  logic        wb_done;
  logic [15:0] om_data;
  logic        om_valid;
  logic        om_ready;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_hen;
  logic        mem_ack;

  wb_dma dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_base   (wb_base),
    .wb_len    (wb_len),
    .wb_done   (wb_done),
    .om_data   (om_data),
    .om_valid  (om_valid),
    .om_ready  (om_ready),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_hen   (mem_hen),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [23:0]       base;
    logic [15:0]       len;
    logic [3:0][15:0]  el;
    int                gap;
    int                ackdly;
    int                nw;
    logic [1:0][23:0]  ea;
    logic [1:0][31:0]  ed;
    logic [1:0][1:0]   eh;
    int                lat;
  } vec_t;

  logic [23:0] got_a [4];
  logic [31:0] got_d [4];
  logic [1:0]  got_h [4];
  int          got_n;
  int          got_done;
  int          got_lat;
  int          got_bad;
  int          got_tmo;

  task automatic run_cmd(input vec_t v);
    int acc;
    int idx;
    int gapcnt;
    int reqcnt;
    int done_cyc;
    got_n = 0;
    got_done = 0;
    got_bad = 0;
    got_tmo = 1;
    done_cyc = 0;
    idx = 0;
    gapcnt = 0;
    reqcnt = 0;
    @(negedge clk);
    wb_valid = 1'b1;
    wb_base  = v.base;
    wb_len   = v.len;
    @(negedge clk);
    wb_valid = 1'b0;
    wb_base  = 24'h5A5A5A;
    wb_len   = 16'h0003;
    acc = cyc;
    for (int t = 0; t < 200; t++) begin
      if (t > 0) @(negedge clk);
      if (wb_done) begin
        if (got_done == 0) done_cyc = cyc;
        got_done++;
      end
      if (got_done > 0 && wb_ready) begin
        got_tmo = 0;
        break;
      end
      if (idx < int'(v.len) && idx < 4 && gapcnt == 0) begin
        om_valid = 1'b1;
        om_data  = v.el[idx];
      end else begin
        om_valid = 1'b0;
        om_data  = 16'hDEAD;
        if (gapcnt > 0) gapcnt--;
      end
      if (om_valid && om_ready) begin
        idx++;
        gapcnt = v.gap;
      end
      if (mem_req) begin
        if (om_ready) got_bad++;
        if (reqcnt == 0) begin
          if (got_n < 4) begin
            got_a[got_n] = mem_addr;
            got_d[got_n] = mem_wdata;
            got_h[got_n] = mem_hen;
          end
          got_n++;
        end else if (got_n <= 4) begin
          if (mem_addr !== got_a[got_n-1] ||
              mem_wdata !== got_d[got_n-1] ||
              mem_hen !== got_h[got_n-1]) got_bad++;
        end
        reqcnt++;
        mem_ack = (reqcnt == v.ackdly + 1);
      end else begin
        reqcnt = 0;
        mem_ack = 1'b0;
      end
    end
    om_valid = 1'b0;
    mem_ack  = 1'b0;
    got_lat  = done_cyc - acc + 1;
  endtask

  vec_t tv [7];

  initial begin
    int bad;
    logic [23:0] sa;
    logic [31:0] sd;
    logic [1:0]  sh;

    tv[0] = '{24'h000010, 16'd4,
              {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 0, 0, 2,
              {24'h000011, 24'h000010},
              {32'h44443333, 32'h22221111}, {2'b11, 2'b11}, 7};
    tv[1] = '{24'h000020, 16'd3,
              {16'h0000, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 0, 0, 2,
              {24'h000021, 24'h000020},
              {32'h0000CCCC, 32'hBBBBAAAA}, {2'b01, 2'b11}, 6};
    tv[2] = '{24'h000100, 16'd2,
              {16'h0000, 16'h0000, 16'hABCD, 16'h1234}, 0, 0, 1,
              {24'h000000, 24'h000100},
              {32'h00000000, 32'hABCD1234}, {2'b00, 2'b11}, 4};
    tv[3] = '{24'h000005, 16'd1,
              {16'h0000, 16'h0000, 16'h0000, 16'hBEEF}, 0, 0, 1,
              {24'h000000, 24'h000005},
              {32'h00000000, 32'h0000BEEF}, {2'b00, 2'b01}, 3};
    tv[4] = '{24'hFFFFFF, 16'd4,
              {16'h0708, 16'h0506, 16'h0304, 16'h0102}, 3, 0, 2,
              {24'h000000, 24'hFFFFFF},
              {32'h07080506, 32'h03040102}, {2'b11, 2'b11}, 15};
    tv[5] = '{24'h000040, 16'd2,
              {16'h0000, 16'h0000, 16'hF0F0, 16'h0F0F}, 0, 3, 1,
              {24'h000000, 24'h000040},
              {32'h00000000, 32'hF0F00F0F}, {2'b00, 2'b11}, 7};
    tv[6] = '{24'h000077, 16'd0,
              {16'h1, 16'h2, 16'h3, 16'h4}, 0, 0, 0,
              {24'h000000, 24'h000000},
              {32'h0, 32'h0}, {2'b00, 2'b00}, 1};

    rst_n    = 1'b0;
    wb_valid = 1'b0;
    wb_base  = '0;
    wb_len   = '0;
    om_data  = '0;
    om_valid = 1'b0;
    mem_ack  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(wb_ready), 64'd1);
    chk("rst_outs",
        {wb_done, om_ready, mem_req, mem_hen, mem_addr, mem_wdata},
        64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_cmd(tv[i]);
      chk($sformatf("v%0d_tmo", i), 64'(got_tmo), 64'd0);
      chk($sformatf("v%0d_nw", i), 64'(got_n), 64'(tv[i].nw));
      for (int w = 0; w < tv[i].nw && w < 2; w++) begin
        chk($sformatf("v%0d_addr%0d", i, w), 64'(got_a[w]),
            64'(tv[i].ea[w]));
        chk($sformatf("v%0d_data%0d", i, w), 64'(got_d[w]),
            64'(tv[i].ed[w]));
        chk($sformatf("v%0d_hen%0d", i, w), 64'(got_h[w]),
            64'(tv[i].eh[w]));
      end
      chk($sformatf("v%0d_done", i), 64'(got_done), 64'd1);
      chk($sformatf("v%0d_lat", i), 64'(got_lat), 64'(tv[i].lat));
      chk($sformatf("v%0d_stable", i), 64'(got_bad), 64'd0);
    end

    // Backpressure: ack held off 5 cycles, busy command ignored.
    @(negedge clk);
    wb_valid = 1'b1;
    wb_base  = 24'h000200;
    wb_len   = 16'd2;
    @(negedge clk);
    wb_valid = 1'b0;
    om_valid = 1'b1;
    om_data  = 16'h1357;
    @(negedge clk);
    om_data  = 16'h2468;
    @(negedge clk);
    om_data  = 16'h5555;
    wb_valid = 1'b1;
    wb_base  = 24'h000999;
    wb_len   = 16'd1;
    chk("bp_req", 64'(mem_req), 64'd1);
    chk("bp_word", {mem_hen, mem_addr, mem_wdata},
        {6'd0, 2'b11, 24'h000200, 32'h24681357});
    sa = mem_addr;
    sd = mem_wdata;
    sh = mem_hen;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (!mem_req || om_ready || wb_done || wb_ready) bad++;
      if (mem_addr !== sa || mem_wdata !== sd || mem_hen !== sh) bad++;
      mem_ack = (k == 5);
    end
    chk("bp_stable", 64'(bad), 64'd0);
    @(negedge clk);
    mem_ack  = 1'b0;
    wb_valid = 1'b0;
    chk("bp_done", {wb_done, mem_req, om_ready}, 64'b100);
    @(negedge clk);
    chk("bp_idle", {wb_ready, wb_done, mem_req, om_ready}, 64'b1000);
    @(negedge clk);
    chk("bp_ignored", {wb_ready, om_ready}, 64'b10);
    om_valid = 1'b0;

    // Asynchronous reset while a write is pending.
    @(negedge clk);
    wb_valid = 1'b1;
    wb_base  = 24'h000300;
    wb_len   = 16'd2;
    @(negedge clk);
    wb_valid = 1'b0;
    om_valid = 1'b1;
    om_data  = 16'h1111;
    @(negedge clk);
    om_data  = 16'h2222;
    @(negedge clk);
    om_valid = 1'b0;
    chk("ar_req", 64'(mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ready", 64'(wb_ready), 64'd1);
    chk("ar_outs",
        {wb_done, om_ready, mem_req, mem_hen, mem_addr, mem_wdata},
        64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (wb_done || mem_req || !wb_ready) bad++;
    end
    chk("ar_after", 64'(bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
